// File: rtl/membus_ram_responder_pkg.sv
// ============================================================================
// membus_ram_responder_pkg : shared membus types and RAM memory-map constants
// Rev 1.0
// ============================================================================
`default_nettype none

package membus_ram_responder_pkg;

  localparam int          MEMBUS_DATA_WIDTH = 64;
  localparam int          RAM_ADDR_WIDTH    = 16;
  localparam logic [63:0] MMAP_RAM_BEGIN    = 64'h8000_0000;

  typedef logic [63:0] Addr;

  typedef struct packed {
    Addr         addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } membus_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } membus_rsp_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rsp_state_e;

endpackage

`default_nettype wire

// File: rtl/membus_ram_responder_ram_bytemask.sv
// ============================================================================
// ram_bytemask : single-port synchronous RAM, per-byte write enable, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_bytemask #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read register only moves on a read, so it holds its value through stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !wen) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (en && wen) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wmask[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/membus_ram_responder.sv
// ============================================================================
// membus_ram_responder : membus target serving requests from an on-chip RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module membus_ram_responder
  import membus_ram_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter logic [63:0] BASE       = MMAP_RAM_BEGIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  membus_req_t           req;
  Addr                   off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  rsp_state_e state_d, state_q;
  logic       is_read_d, is_read_q;
  logic       err_d, err_q;

  assign req = '{addr: req_addr, wen: req_wen, wdata: req_wdata, wmask: req_wmask};

  // Addresses below BASE wrap to a huge offset and fall out of range naturally.
  assign off      = req.addr - BASE;
  assign in_range = (req.addr >= BASE) && ((off >> (ADDR_WIDTH + 3)) == '0);
  assign idx      = off[ADDR_WIDTH+2:3];

  assign rsp_valid = (state_q == ST_RESP);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready && !accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      is_read_d = in_range && !req.wen;
      err_d     = !in_range;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
    end
  end

  ram_bytemask #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (accept && in_range),
    .wen   (req.wen),
    .wmask (req.wmask),
    .addr  (idx),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  // Writes and errors report zero data; the RAM read register is only exposed for reads.
  assign rsp_rdata = is_read_q ? ram_rdata : '0;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_membus_ram_responder.sv
// ============================================================================
// tb_membus_ram_responder : randomized scoreboard bench for membus_ram_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_membus_ram_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] WIN  = 64'd8 << 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mdl[longint];
  int          tests = 0;
  int          fails = 0;

  membus_ram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < WIN);
  endfunction

  // Reference behaviour: a word-addressed dictionary, updated at accept time.
  task automatic model_accept(input logic [63:0] a, input logic w,
                              input logic [63:0] d, input logic [7:0] m);
    exp_t        e;
    longint      k;
    logic [63:0] cur;
    e.rdata = '0;
    e.err   = 1'b0;
    if (!in_win(a)) begin
      e.err = 1'b1;
    end else begin
      k   = longint'((a - BASE) / 8);
      cur = mdl.exists(k) ? mdl[k] : 64'h0;
      if (w) begin
        for (int i = 0; i < 8; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
        mdl[k] = cur;
      end else begin
        e.rdata = cur;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic w,
                       input logic [63:0] d, input logic [7:0] m, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_wmask = m;
    rsp_ready = rr;
    @(negedge clk);
    #1;
    if (rst && req_valid && req_ready) model_accept(a, w, d, m);
  endtask

  // Monitor: samples on the falling edge, before the driver decides on accepts.
  logic        have_prev = 1'b0;
  logic        prev_valid, prev_ready, prev_err;
  logic [63:0] prev_rdata;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 1'b0;
    end else begin
      chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_q.size() != 0});
      chk("req_ready", {63'b0, req_ready}, {63'b0, (exp_q.size() == 0) || rsp_ready});
      if (rsp_valid && exp_q.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", {63'b0, rsp_err}, {63'b0, exp_q[0].err});
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (have_prev && ((prev_valid && !prev_ready && rsp_valid) || !rsp_valid)) begin
        chk("stable_rdata", rsp_rdata, prev_rdata);
        chk("stable_err", {63'b0, rsp_err}, {63'b0, prev_err});
      end
      have_prev  = 1'b1;
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    int          k;
    #1;
    chk("reset_valid", {63'b0, rsp_valid}, 64'h0);
    chk("reset_rdata", rsp_rdata, 64'h0);
    chk("reset_err", {63'b0, rsp_err}, 64'h0);
    #20;
    rst = 1'b1;

    // Give every word the random traffic touches a known value.
    for (int i = 0; i < 16; i++) drive(1, BASE + 64'(i) * 8, 1, {$urandom, $urandom}, 8'hff, 1);
    drive(1, BASE + 64'hFFFF * 8, 1, {$urandom, $urandom}, 8'hff, 1);

    // Preload and read word 0
    drive(1, BASE, 1, 64'h0123_4567_89ab_cdef, 8'hff, 1);
    drive(1, BASE, 0, '0, '0, 1);
    // Partial mask over zero
    drive(1, BASE + 8, 1, 64'h0, 8'hff, 1);
    drive(1, BASE + 8, 1, 64'hffff_ffff_ffff_ffff, 8'h0f, 1);
    drive(1, BASE + 8, 0, '0, '0, 1);
    // Back-to-back write then read of the same word
    drive(1, BASE + 16, 1, 64'h55, 8'hff, 1);
    drive(1, BASE + 16, 0, '0, '0, 1);
    chk("b2b_ready", {63'b0, req_ready}, 64'h1);
    // Back-pressure: 3 stalled cycles, then release accepts the waiting request
    drive(1, BASE + 16, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) drive(1, BASE, 0, '0, '0, 0);
    drive(1, BASE, 0, '0, '0, 1);
    // Out-of-range reads, and a write that must not alias word 0
    drive(1, 64'h7fff_fff8, 0, '0, '0, 1);
    drive(1, 64'h8008_0000, 0, '0, '0, 1);
    drive(1, 64'h8008_0000, 1, 64'hdead_beef_dead_beef, 8'hff, 1);
    drive(1, BASE, 0, '0, '0, 1);
    // Wrong-way hazard: read then write returns old data
    drive(1, BASE + 32, 0, '0, '0, 1);
    drive(1, BASE + 32, 1, 64'h1111_2222_3333_4444, 8'hff, 1);
    drive(1, BASE + 32, 0, '0, '0, 1);

    // Reset with a response pending; prior writes must survive
    drive(1, BASE + 24, 1, 64'hcafe_f00d_1234_5678, 8'hff, 1);
    drive(1, BASE + 16, 0, '0, '0, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_rst_valid", {63'b0, rsp_valid}, 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {63'b0, rsp_valid}, 64'h0);
    chk("async_rst_rdata", rsp_rdata, 64'h0);
    chk("async_rst_err", {63'b0, rsp_err}, 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(1, BASE + 24, 0, '0, '0, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 7) begin
        a = BASE + 64'(($urandom_range(0, 16) == 16) ? 65535 : $urandom_range(0, 15)) * 8
            + 64'($urandom_range(0, 7));
      end else if (k == 7) begin
        a = BASE - 64'($urandom_range(1, 4)) * 8;
      end else if (k == 8) begin
        a = BASE + WIN + 64'($urandom_range(0, 64)) * 8;
      end else begin
        a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      end
      d = {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1, d,
            8'($urandom), $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 4; i++) drive(0, '0, 0, '0, '0, 1);
    chk("drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/membus_ram_responder.md
Name: membus_ram_responder

Overview:
- Target-side endpoint of the core memory bus: accepts requests from the core's membus initiator and serves them from an internal RAM array mapped at MMAP_RAM_BEGIN.
- Single-cycle read latency, byte-masked writes, and a holdable response stage with back-pressure.
- Sits between the core's memory interface and on-chip storage, in place of a behavioural memory model.

Parameters:
- ADDR_WIDTH, 16, word-index width; RAM holds 2**ADDR_WIDTH 64-bit words.
- DATA_WIDTH, 64, bus and word width (MEMBUS_DATA_WIDTH); only 64 is supported.
- BASE, 64'h8000_0000, byte address of word 0 (MMAP_RAM_BEGIN).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  64  byte address (Addr).
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  64  write data.
- req_wmask  in  8  byte-lane write enable; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  64  read data; 0 for writes and errors.
- rsp_err  out  1  request address was outside the RAM window.

Behaviour:
- Reset (rst low, asynchronous): rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE. RAM contents are not reset.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Ready rule: req_ready = !rsp_valid || rsp_ready, which gives full throughput with back-to-back requests. req_ready is combinational from rsp_ready only, never from req_valid.
- Decode: off = req_addr - BASE.
  - In range iff req_addr >= BASE and off < 2**(ADDR_WIDTH+3).
  - idx = off[ADDR_WIDTH+2:3]; off[2:0] is ignored, so accesses are word-aligned. Misalignment checking belongs to the core.
- Read: on accept, rsp_rdata <= mem[idx], rsp_err <= 0, rsp_valid <= 1. The response is visible the cycle after accept (latency 1).
- Write: on accept, each lane with wmask[i]=1 is written; other lanes are unchanged. The response has rsp_rdata=0, rsp_err=0 and latency 1. wmask=0 is a legal no-op that still gets a response.
- Out of range: no array access and no write; response has rsp_rdata=0, rsp_err=1.
- Response hold: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err are held stable and no new request is accepted.
- Response clear: when rsp_valid && rsp_ready with no new accept in the same cycle, rsp_valid <= 0 next cycle. rsp_rdata and rsp_err keep their last values; they are don't-care, but the bench checks they are stable.
- FSM:
  - IDLE (rsp_valid=0): on accept go to RESP.
  - RESP (rsp_valid=1):
    - rsp_ready && accept: stay in RESP with the new payload.
    - rsp_ready && !accept: go to IDLE.
    - !rsp_ready: stay in RESP and hold.
- Hazards:
  - Write then read of the same word in consecutive accepts returns the new data, because the write commits at the accept edge before the read samples.
  - Read then write of the same word returns the old data.
- Reset mid-operation: a pending response is dropped. Writes accepted at or before the last rising edge before reset assertion are kept in the array.
- Widths: the subtraction is 64-bit unsigned. An address below BASE wraps to a large offset and is therefore out of range.

Decomposition:
- Shared package: MEMBUS_DATA_WIDTH, RAM_ADDR_WIDTH, MMAP_RAM_BEGIN, Addr.
- New in the same package: typedef of the membus request struct (addr, wen, wdata, wmask) and the response struct (rdata, err), so initiator and responder share one definition.
- One sub-module: ram_bytemask (synchronous single-port 64-bit array, per-byte write enable, registered read). The responder wraps it with decode and the response FSM.

Test Plan:
- Reset, then read addr 0x8000_0000 -> rsp_valid one cycle after accept, rdata = preloaded 64'h0123_4567_89ab_cdef, err=0.
- Write 0x8000_0008, wdata 64'hffff_ffff_ffff_ffff, wmask 8'h0f, over an old value of 0; then read the same address -> rdata 64'h0000_0000_ffff_ffff.
- Back-to-back accepts with rsp_ready=1 every cycle: write 0x8000_0010 = 64'h55 (mask 8'hff), then read it on the next cycle -> 64'h55; req_ready stays 1 throughout.
- Hold rsp_ready=0 for 3 cycles after a read -> req_ready=0, rsp_rdata stable for 3 cycles, no second accept; release -> next request accepted in that same cycle.
- Read 0x7fff_fff8 and 0x8008_0000 (ADDR_WIDTH=16) -> rsp_err=1, rdata=0; a write to 0x8008_0000 leaves word 0 unmodified.
- Assert rst while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous); after release, read back a word written before reset -> written data returned.
